// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: front-end controller for the two-digit calculator.
// It collects two 2-digit BCD operands from button pulses, computes the
// binary result of the selected operation, and converts that result to
// four BCD digits with a double-dabble converter that does one shift per
// clock. It also drives the sign/error flags and the busy/done handshake.
//
// Build option: define CALC_MUL_EN to enable op 10 (multiply). When it is
// undefined, no multiplier is built and op 10 raises err like op 11. The
// conversion latency is the same in both builds.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_ENTRY   | operand entry; digits mirror e1..e4, buttons edit or exec
// S_LOAD    | one cycle: compute the binary result, set flags, prime converter
// S_CONVERT | CONV_BITS double-dabble iterations; all buttons ignored
// S_SHOW    | result displayed; btn_exec returns to entry

module calc_op_sequencer #(
   parameter int CONV_BITS = 14,
   parameter int DIGIT_MAX = 9
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_inc,
   input  logic       btn_next,
   input  logic       btn_exec,
   input  logic [1:0] op_sel,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic [3:0] digit3,
   output logic [3:0] digit4,
   output logic [1:0] cursor,
   output logic       neg,
   output logic       err,
   output logic       busy,
   output logic       done
);

   localparam int CW = $clog2(CONV_BITS + 1);

   typedef enum logic [1:0] {
      S_ENTRY   = 2'd0,
      S_LOAD    = 2'd1,
      S_CONVERT = 2'd2,
      S_SHOW    = 2'd3
   } state_t;

   state_t state, state_nxt;

   // e[0] is the most significant entry digit (shown on digit1)
   logic [3:0][3:0]       e;
   logic [1:0]            op;
   logic [CONV_BITS-1:0]  sr;
   logic [15:0]           bcd;
   logic [15:0]           bcd_adj;
   logic [15:0]           bcd_shift;
   logic [15:0]           res;
   logic [CW-1:0]         cnt;
   logic                  tc;

   logic [6:0]            num1;
   logic [6:0]            num2;
   logic [CONV_BITS-1:0]  r_calc;
   logic                  neg_calc;
   logic                  err_calc;

   // Down-counter reaching zero marks the final conversion iteration
   assign tc = (cnt == '0);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_ENTRY;
      else          state <= state_nxt;
   end

   // Next-state decode and busy flag
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      case (state)
         S_ENTRY:   if (btn_exec) state_nxt = S_LOAD;
         S_LOAD:    begin
                       busy      = 1'b1;
                       state_nxt = S_CONVERT;
                    end
         S_CONVERT: begin
                       busy = 1'b1;
                       if (tc) state_nxt = S_SHOW;
                    end
         S_SHOW:    if (btn_exec) state_nxt = S_ENTRY;
         default:   state_nxt = S_ENTRY;
      endcase
   end

   // Binary operands from the entry digits
   always_comb begin
      num1 = 7'(e[0]) * 7'd10 + 7'(e[1]);
      num2 = 7'(e[2]) * 7'd10 + 7'(e[3]);
   end

   // Arithmetic on the latched op; subtraction yields magnitude plus sign
   always_comb begin
      r_calc   = '0;
      neg_calc = 1'b0;
      err_calc = 1'b0;
      case (op)
         2'b00: r_calc = CONV_BITS'(num1) + CONV_BITS'(num2);
         2'b01: begin
                   if (num1 >= num2) begin
                      r_calc = CONV_BITS'(num1 - num2);
                   end else begin
                      r_calc   = CONV_BITS'(num2 - num1);
                      neg_calc = 1'b1;
                   end
                end
`ifdef CALC_MUL_EN
         2'b10: r_calc = CONV_BITS'(num1) * CONV_BITS'(num2);
`endif
         default: err_calc = 1'b1;
      endcase
   end

   // Double-dabble step: add 3 to nibbles >= 5, then shift in the next MSB
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 4; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      bcd_shift = 16'({bcd_adj, sr[CONV_BITS-1]});
   end

   // Operand entry, result computation, conversion and flag registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         e      <= '0;
         cursor <= 2'd0;
         op     <= 2'b00;
         sr     <= '0;
         bcd    <= '0;
         res    <= '0;
         cnt    <= '0;
         neg    <= 1'b0;
         err    <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_ENTRY: begin
               if (btn_exec) begin
                  op <= op_sel;
               end else if (btn_next) begin
                  cursor <= cursor + 2'd1;
               end else if (btn_inc) begin
                  if (e[cursor] >= 4'(DIGIT_MAX)) e[cursor] <= 4'd0;
                  else                             e[cursor] <= e[cursor] + 4'd1;
               end
            end
            S_LOAD: begin
               sr  <= r_calc;
               neg <= neg_calc;
               err <= err_calc;
               bcd <= '0;
               cnt <= CW'(CONV_BITS - 1);
            end
            S_CONVERT: begin
               sr  <= sr << 1;
               bcd <= bcd_shift;
               if (tc) begin
                  res  <= bcd_shift;
                  done <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_SHOW: begin
               if (btn_exec) begin
                  neg <= 1'b0;
                  err <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Display mux: result only in SHOW, otherwise the operand mirror
   always_comb begin
      if (state == S_SHOW) begin
         {digit1, digit2, digit3, digit4} = res;
      end else begin
         digit1 = e[0];
         digit2 = e[1];
         digit3 = e[2];
         digit4 = e[3];
      end
   end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed testbench for calc_op_sequencer: entry editing, add/sub/mul/
// reserved ops, latency and done pulse, button priority, reset mid-convert.
module tb_calc_op_sequencer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       btn_inc = 1'b0;
   logic       btn_next = 1'b0;
   logic       btn_exec = 1'b0;
   logic [1:0] op_sel = 2'b00;
   logic [3:0] digit1, digit2, digit3, digit4;
   logic [1:0] cursor;
   logic       neg, err, busy, done;

   int checks = 0;
   int failures = 0;

   calc_op_sequencer dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .btn_inc  (btn_inc),
      .btn_next (btn_next),
      .btn_exec (btn_exec),
      .op_sel   (op_sel),
      .digit1   (digit1),
      .digit2   (digit2),
      .digit3   (digit3),
      .digit4   (digit4),
      .cursor   (cursor),
      .neg      (neg),
      .err      (err),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   wire [15:0] digs = {digit1, digit2, digit3, digit4};

   // Inputs change on the falling edge; each press lasts one rising edge.
   task automatic press(input logic inc, input logic nxt, input logic exe);
      btn_inc = inc; btn_next = nxt; btn_exec = exe;
      @(negedge clk);
      btn_inc = 1'b0; btn_next = 1'b0; btn_exec = 1'b0;
   endtask

   task automatic do_reset();
      btn_inc = 1'b0; btn_next = 1'b0; btn_exec = 1'b0; op_sel = 2'b00;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   // Enter four digits starting at cursor 0; cursor wraps back to 0.
   task automatic enter(input int a, input int b, input int c, input int d);
      int v[4];
      v = '{a, b, c, d};
      for (int i = 0; i < 4; i++) begin
         repeat (v[i]) press(1'b1, 1'b0, 1'b0);
         press(1'b0, 1'b1, 1'b0);
      end
   endtask

   // Run one calculation from ENTRY and check latency, result and return.
   task automatic calc(input string name, input logic [1:0] op,
                       input logic [15:0] exp_dig, input logic exp_neg,
                       input logic exp_err, input logic [15:0] back_dig);
      int n;
      op_sel = op;
      press(1'b0, 1'b0, 1'b1);
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != 15) begin
         failures++;
         $display("FAIL %s busy_cycles got=%0d exp=15", name, n);
      end
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL %s done_first got=%b exp=1", name, done);
      end
      checks++;
      if (digs !== exp_dig) begin
         failures++;
         $display("FAIL %s digits got=%h exp=%h", name, digs, exp_dig);
      end
      checks++;
      if (neg !== exp_neg || err !== exp_err) begin
         failures++;
         $display("FAIL %s flags got neg=%b err=%b exp neg=%b err=%b",
                  name, neg, err, exp_neg, exp_err);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || digs !== exp_dig) begin
         failures++;
         $display("FAIL %s done_pulse got done=%b dig=%h exp done=0 dig=%h",
                  name, done, digs, exp_dig);
      end
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b1, 1'b0);
      checks++;
      if (digs !== exp_dig || busy !== 1'b0 || cursor !== 2'd0) begin
         failures++;
         $display("FAIL %s show_ignore got dig=%h busy=%b cur=%0d exp dig=%h busy=0 cur=0",
                  name, digs, busy, cursor, exp_dig);
      end
      press(1'b0, 1'b0, 1'b1);
      checks++;
      if (digs !== back_dig || neg !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s return got dig=%h neg=%b err=%b busy=%b exp dig=%h neg=0 err=0 busy=0",
                  name, digs, neg, err, busy, back_dig);
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (digs !== 16'h0000 || cursor !== 2'd0 || {neg, err, busy, done} !== 4'b0000) begin
         failures++;
         $display("FAIL reset got dig=%h cur=%0d nebd=%b exp 0000/0/0000",
                  digs, cursor, {neg, err, busy, done});
      end
   endtask

   task automatic test_entry();
      do_reset();
      repeat (3) press(1'b1, 1'b0, 1'b0);
      checks++;
      if (digit1 !== 4'd3 || cursor !== 2'd0) begin
         failures++;
         $display("FAIL entry_inc got d1=%0d cur=%0d exp d1=3 cur=0", digit1, cursor);
      end
      press(1'b0, 1'b1, 1'b0);
      press(1'b0, 1'b1, 1'b0);
      checks++;
      if (cursor !== 2'd2) begin
         failures++;
         $display("FAIL entry_next got cur=%0d exp=2", cursor);
      end
      press(1'b0, 1'b1, 1'b0);
      press(1'b0, 1'b1, 1'b0);
      checks++;
      if (cursor !== 2'd0) begin
         failures++;
         $display("FAIL entry_cursor_wrap got cur=%0d exp=0", cursor);
      end
      repeat (6) press(1'b1, 1'b0, 1'b0);
      checks++;
      if (digit1 !== 4'd9) begin
         failures++;
         $display("FAIL entry_nine got d1=%0d exp=9", digit1);
      end
      press(1'b1, 1'b0, 1'b0);
      checks++;
      if (digs !== 16'h0000) begin
         failures++;
         $display("FAIL entry_digit_wrap got dig=%h exp=0000", digs);
      end
   endtask

   task automatic test_add();
      do_reset();
      enter(4, 7, 2, 5);
      checks++;
      if (digs !== 16'h4725) begin
         failures++;
         $display("FAIL add_mirror got dig=%h exp=4725", digs);
      end
      calc("add_47_25", 2'b00, 16'h0072, 1'b0, 1'b0, 16'h4725);
   endtask

   task automatic test_sub();
      do_reset();
      enter(1, 2, 3, 4);
      calc("sub_12_34", 2'b01, 16'h0022, 1'b1, 1'b0, 16'h1234);
      do_reset();
      enter(3, 4, 1, 2);
      calc("sub_34_12", 2'b01, 16'h0022, 1'b0, 1'b0, 16'h3412);
      do_reset();
      calc("sub_zero", 2'b01, 16'h0000, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic test_mul();
      do_reset();
      enter(9, 9, 9, 9);
`ifdef CALC_MUL_EN
      calc("mul_99_99", 2'b10, 16'h9801, 1'b0, 1'b0, 16'h9999);
`else
      calc("mul_disabled", 2'b10, 16'h0000, 1'b0, 1'b1, 16'h9999);
`endif
      calc("op_reserved", 2'b11, 16'h0000, 1'b0, 1'b1, 16'h9999);
   endtask

   task automatic test_priority();
      int n;
      do_reset();
      enter(1, 2, 3, 4);
      op_sel = 2'b00;
      press(1'b1, 1'b1, 1'b1);
      checks++;
      if (busy !== 1'b1 || digs !== 16'h1234 || cursor !== 2'd0) begin
         failures++;
         $display("FAIL prio_exec got busy=%b dig=%h cur=%0d exp busy=1 dig=1234 cur=0",
                  busy, digs, cursor);
      end
      repeat (3) @(negedge clk);
      press(1'b1, 1'b0, 1'b0);
      press(1'b0, 1'b1, 1'b0);
      checks++;
      if (busy !== 1'b1 || digs !== 16'h1234) begin
         failures++;
         $display("FAIL prio_convert_hold got busy=%b dig=%h exp busy=1 dig=1234", busy, digs);
      end
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (digs !== 16'h0046 || done !== 1'b1 || n > 13) begin
         failures++;
         $display("FAIL prio_result got dig=%h done=%b wait=%0d exp dig=0046 done=1", digs, done, n);
      end
      press(1'b0, 1'b0, 1'b1);
      checks++;
      if (digs !== 16'h1234 || cursor !== 2'd0) begin
         failures++;
         $display("FAIL prio_operands got dig=%h cur=%0d exp dig=1234 cur=0", digs, cursor);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      enter(5, 5, 5, 5);
      op_sel = 2'b01;
      press(1'b1, 1'b0, 1'b1);
      repeat (6) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL midrst_busy got=%b exp=1", busy);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (digs !== 16'h0000 || cursor !== 2'd0 || {neg, err, busy, done} !== 4'b0000) begin
         failures++;
         $display("FAIL midrst_async got dig=%h cur=%0d nebd=%b exp 0000/0/0000",
                  digs, cursor, {neg, err, busy, done});
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || digs !== 16'h0000 || done !== 1'b0) begin
         failures++;
         $display("FAIL midrst_idle got busy=%b dig=%h done=%b exp 0/0000/0", busy, digs, done);
      end
      calc("midrst_zero", 2'b00, 16'h0000, 1'b0, 1'b0, 16'h0000);
   endtask

   initial begin
      test_reset();
      test_entry();
      test_add();
      test_sub();
      test_mul();
      test_priority();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Front-end controller for the two-digit calculator datapath. Collects two 2-digit BCD operands from single-cycle button pulses and latches the operation on execute.
- Computes the binary result, then sequences a multi-cycle binary-to-BCD conversion (double-dabble, one shift per clock).
- Drives the four 7-seg digit nibbles, sign and error flags, plus busy/done handshakes to the display mux.

Parameters:
- CONV_BITS, 14, width of the binary result register and the number of double-dabble iterations (9801 < 2^14).
- DIGIT_MAX, 9, max value of an entry digit before wrap to 0.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- btn_inc  input  1  single-cycle pulse, debounced and synchronous upstream; increments the digit under the cursor
- btn_next  input  1  single-cycle pulse; advances the cursor
- btn_exec  input  1  single-cycle pulse; starts a calculation, or returns to entry from SHOW
- op_sel  input  2  00 add, 01 sub, 10 mul, 11 reserved; sampled on exec
- digit1, digit2, digit3, digit4  output  4 each  BCD display digits, digit1 = most significant
- cursor  output  2  index of the digit being edited (0 = digit1)
- neg  output  1  result is negative (sub only)
- err  output  1  illegal or disabled op
- busy  output  1  high in LOAD and CONVERT
- done  output  1  one-cycle pulse on entry to SHOW

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=ENTRY; operands e1..e4=0; cursor=0.
  - digit1..4=0; neg=err=busy=done=0; internal result and shift registers cleared.
- Simultaneous pulses: priority is btn_exec > btn_next > btn_inc; lower-priority pulses in the same cycle are dropped.
- ENTRY:
  - digitN mirrors eN combinationally.
  - btn_inc: e[cursor] += 1, wrapping 9->0.
  - btn_next: cursor += 1, wrapping 3->0.
  - btn_exec: latch op_sel, go to LOAD. Operands are retained.
- LOAD (1 cycle):
  - num1=e1*10+e2, num2=e3*10+e4, both 7-bit.
  - add: r = num1+num2 (max 198).
  - sub: if num1>=num2, r = num1-num2 and neg=0; otherwise r = num2-num1 and neg=1.
  - mul: r = num1*num2 (max 9801).
  - op 11: err=1, r=0.
  - Zero-extend r to CONV_BITS and load the shift register. Clear the BCD accumulator and the iteration counter. Go to CONVERT.
- CONVERT (exactly CONV_BITS cycles):
  - Each cycle, add 3 to every BCD nibble >=5, then shift left one bit, pulling in the next result MSB.
  - After the final iteration, write the accumulator to digit1..4 and go to SHOW.
- Display during LOAD/CONVERT: digit1..4 hold their ENTRY values. All buttons are ignored.
- SHOW:
  - digits hold the result; done=1 in the first SHOW cycle only.
  - btn_exec: clear neg and err, go to ENTRY. Digits revert to the operand mirror.
  - btn_inc and btn_next are ignored.
- Latency: btn_exec sampled at edge k -> busy high after edge k -> digits valid and done high after edge k+1+CONV_BITS (15 cycles at default).
- busy is 0 in ENTRY and SHOW.
- Reset mid-CONVERT aborts immediately to the reset values; no partial result is ever displayed.
- Leading zeros are displayed; no blanking.

Optional Feature:
- CALC_MUL_EN defined: op 10 performs multiply as above.
- CALC_MUL_EN undefined:
  - No multiplier is synthesised; op 10 behaves like op 11 (err=1, result 0000, full CONVERT latency preserved).
  - Max result is then 198. CONV_BITS is still used unchanged, so timing is identical.

Test Plan:
- Reset then 3x btn_inc -> digit1=3, cursor=0; btn_next x4 -> cursor=0 (wrap); 10x btn_inc on one digit -> digit back to 0.
- Enter 4,7,2,5, op 00, exec -> busy high for 15 cycles, done single pulse, digits 0,0,7,2, neg=0.
- Enter 1,2,3,4, op 01 -> digits 0,0,2,2, neg=1; enter 3,4,1,2, op 01 -> 0,0,2,2, neg=0; 0,0,0,0 sub -> 0000, neg=0.
- Enter 9,9,9,9, op 10 -> 9,8,0,1 with CALC_MUL_EN; err=1 and 0000 without it. Op 11 -> err=1 and 0000 in both builds.
- Same-cycle btn_inc+btn_next+btn_exec in ENTRY -> exec taken, operands unchanged; btn_inc during CONVERT -> no effect.
- Assert reset_n low mid-CONVERT (cycle 6) -> all outputs 0 asynchronously, state ENTRY; after release, exec with operands 00,00 -> 0000.
